// File: rtl/zbb_wb_buffer.sv
`default_nettype none
// ============================================================================
// zbb_wb_buffer : writeback result select + 2-entry in-order skid buffer.
// Optional ZBB_WB_PERF_EN adds the zbb_retired counter.        Rev 1.0
// ============================================================================
module zbb_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_regWrite,
  input  logic            in_isAlu,
  input  logic            in_isZbb,
  input  logic [XLEN-1:0] in_aluResult,
  input  logic [XLEN-1:0] in_zbbResult,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_wd,
  output logic            out_we,
  output logic            out_illegal
`ifdef ZBB_WB_PERF_EN
  ,
  output logic [31:0]     zbb_retired
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic            push, pop;

  logic [XLEN-1:0] ent_wd;
  logic            ent_we;
  logic            ent_ill;

  logic [4:0]      rd_q  [DEPTH];
  logic [XLEN-1:0] wd_q  [DEPTH];
  logic            we_q  [DEPTH];
  logic            ill_q [DEPTH];

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Zbb claim outranks the base ALU; writes to x0 and unclaimed ops carry zero data.
  always_comb begin
    ent_ill = !in_isZbb && !in_isAlu;
    ent_we  = in_regWrite && !ent_ill && (in_rd != 5'd0);
    if (ent_ill || (in_rd == 5'd0)) begin
      ent_wd = '0;
    end else if (in_isZbb) begin
      ent_wd = in_zbbResult;
    end else begin
      ent_wd = in_aluResult;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = S_EMPTY;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case (state_q)
        S_EMPTY: if (push) state_d = S_ONE;
        S_ONE: begin
          if (push && !pop)      state_d = S_FULL;
          else if (pop && !push) state_d = S_EMPTY;
        end
        S_FULL:  if (pop) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        wd_q[i]  <= '0;
        we_q[i]  <= 1'b0;
        ill_q[i] <= 1'b0;
      end
    end else if (push && !flush) begin
      rd_q[tail_q]  <= in_rd;
      wd_q[tail_q]  <= ent_wd;
      we_q[tail_q]  <= ent_we;
      ill_q[tail_q] <= ent_ill;
    end
  end

  // Stale slot contents are masked so an empty buffer presents all-zero outputs.
  assign out_rd      = out_valid ? rd_q[head_q]  : '0;
  assign out_wd      = out_valid ? wd_q[head_q]  : '0;
  assign out_we      = out_valid && we_q[head_q];
  assign out_illegal = out_valid && ill_q[head_q];

`ifdef ZBB_WB_PERF_EN
  logic        zbb_q [DEPTH];
  logic [31:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        zbb_q[i] <= 1'b0;
      end
    end else if (push && !flush) begin
      zbb_q[tail_q] <= in_isZbb;
    end
  end

  // A pop coinciding with flush is discarded, so it does not retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (pop && !flush && zbb_q[head_q] && !ill_q[head_q]) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign zbb_retired = retired_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zbb_wb_buffer.sv
`timescale 1ns/1ps
// Self-checking bench for zbb_wb_buffer: vector table, directed corner cases,
// and random traffic against a queue-based reference model.
module tb_zbb_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regWrite;
  logic        in_isAlu;
  logic        in_isZbb;
  logic [31:0] in_aluResult;
  logic [31:0] in_zbbResult;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_wd;
  logic        out_we;
  logic        out_illegal;
`ifdef ZBB_WB_PERF_EN
  logic [31:0] zbb_retired;
`endif

  always #5 clk = ~clk;

  zbb_wb_buffer #(.DEPTH(2), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_regWrite  (in_regWrite),
    .in_isAlu     (in_isAlu),
    .in_isZbb     (in_isZbb),
    .in_aluResult (in_aluResult),
    .in_zbbResult (in_zbbResult),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd       (out_rd),
    .out_wd       (out_wd),
    .out_we       (out_we),
    .out_illegal  (out_illegal)
`ifdef ZBB_WB_PERF_EN
    ,
    .zbb_retired  (zbb_retired)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO of formed entries plus a retired counter.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        we;
    logic        ill;
    logic        zbb;
  } ent_t;

  ent_t        q[$];
  int unsigned m_ret;

  function automatic ent_t form(input logic [4:0] rd, input logic rw, input logic alu,
                                input logic zbb, input logic [31:0] ar, input logic [31:0] zr);
    ent_t e;
    e.rd  = rd;
    e.zbb = zbb;
    e.ill = !zbb && !alu;
    e.wd  = (e.ill || rd == 5'd0) ? 32'd0 : (zbb ? zr : ar);
    e.we  = rw && !e.ill && (rd != 5'd0);
    return e;
  endfunction

  task automatic cmp_model();
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_rd", 32'(out_rd), 32'(q[0].rd));
      check("out_wd", out_wd, q[0].wd);
      check("out_we", 32'(out_we), 32'(q[0].we));
      check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end else begin
      check("empty_out_we", 32'(out_we), 32'd0);
      check("empty_out_illegal", 32'(out_illegal), 32'd0);
    end
`ifdef ZBB_WB_PERF_EN
    check("zbb_retired", zbb_retired, m_ret);
`endif
  endtask

  // Entered and left at posedge+1; compares at negedge, updates model at posedge.
  task automatic cycle();
    bit   push, pop;
    ent_t e;
    @(negedge clk);
    cmp_model();
    push = in_valid && (q.size() < 2);
    pop  = (q.size() != 0) && out_ready;
    e    = form(in_rd, in_regWrite, in_isAlu, in_isZbb, in_aluResult, in_zbbResult);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) begin
        if (q[0].zbb && !q[0].ill) m_ret++;
        void'(q.pop_front());
      end
      if (push) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic rw, input logic alu, input logic zbb,
                       input logic [31:0] ar, input logic [31:0] zr);
    in_rd        = rd;
    in_regWrite  = rw;
    in_isAlu     = alu;
    in_isZbb     = zbb;
    in_aluResult = ar;
    in_zbbResult = zr;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    q.delete();
    m_ret = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_out_wd", out_wd, 32'd0);
    check("rst_out_we", 32'(out_we), 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
`ifdef ZBB_WB_PERF_EN
    check("rst_zbb_retired", zbb_retired, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic random_traffic(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      drive(($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom);
      cycle();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        alu;
    logic        zbb;
    logic [31:0] ar;
    logic [31:0] zr;
    logic [31:0] wd;
    logic        we;
    logic        ill;
    int unsigned ret;
  } vec_t;

  vec_t vt[6];

  initial begin
    // rd, rw, isAlu, isZbb, aluResult, zbbResult | wd, we, illegal, cumulative retired
    vt[0] = '{5'd5,  1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0000001F, 32'h0000001F, 1'b1, 1'b0, 1};
    vt[1] = '{5'd0,  1'b1, 1'b1, 1'b0, 32'h12345678, 32'h0BADF00D, 32'h00000000, 1'b0, 1'b0, 1};
    vt[2] = '{5'd7,  1'b1, 1'b0, 1'b0, 32'h12345678, 32'h87654321, 32'h00000000, 1'b0, 1'b1, 1};
    vt[3] = '{5'd9,  1'b1, 1'b1, 1'b1, 32'hAAAA0000, 32'h5555FFFF, 32'h5555FFFF, 1'b1, 1'b0, 2};
    vt[4] = '{5'd31, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h11111111, 32'hCAFEF00D, 1'b0, 1'b0, 2};
    vt[5] = '{5'd3,  1'b1, 1'b1, 1'b0, 32'h00000042, 32'hFFFFFFFF, 32'h00000042, 1'b1, 1'b0, 2};

    do_reset();

    foreach (vt[i]) begin
      drive(vt[i].rd, vt[i].rw, vt[i].alu, vt[i].zbb, vt[i].ar, vt[i].zr);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_out_rd", 32'(out_rd), 32'(vt[i].rd));
      check("vec_out_wd", out_wd, vt[i].wd);
      check("vec_out_we", 32'(out_we), 32'(vt[i].we));
      check("vec_out_illegal", 32'(out_illegal), 32'(vt[i].ill));
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
`ifdef ZBB_WB_PERF_EN
      check("vec_zbb_retired", zbb_retired, vt[i].ret);
`endif
    end

    // Backpressure: third push refused while full, then re-presented.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(5'd1, 1'b1, 1'b1, 1'b0, 32'h11, 32'h0);
    cycle();
    drive(5'd2, 1'b1, 1'b1, 1'b0, 32'h22, 32'h0);
    cycle();
    drive(5'd3, 1'b1, 1'b1, 1'b0, 32'h33, 32'h0);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_head_A", out_wd, 32'h11);
    cycle();
    check("bp_head_B", out_wd, 32'h22);
    cycle();
    check("bp_drained", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("bp_head_C", out_wd, 32'h33);
    cycle();

    // Streaming push+pop in ONE keeps count at one.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(5'(k + 10), 1'b1, 1'b1, 1'b0, 32'(k), 32'h0);
      cycle();
      check("stream_out_wd", out_wd, 32'(k));
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    cycle();

    // Flush while full with a pending push and pop.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(5'd4, 1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
    cycle();
    cycle();
    flush     = 1'b1;
    out_ready = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef ZBB_WB_PERF_EN
    check("flush_zbb_retired", zbb_retired, 32'(m_ret));
`endif
    cycle();

    random_traffic(400);

    // Asynchronous reset while full, observed before the next edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(5'd6, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000BEEF);
    cycle();
    cycle();
    check("pre_areset_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    q.delete();
    m_ret = 0;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
`ifdef ZBB_WB_PERF_EN
    check("areset_zbb_retired", zbb_retired, 32'd0);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    random_traffic(60);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
